jtag_master: RTL and testbench
==============================

# jtag_master

JTAG initiator: generates tck/tms/tdi toward a target TAP controller and captures tdo, executing one of four commands per start strobe: DR scan, IR scan, TAP reset, or idle clocks. It sits between the board-level register interface and the JTAG chain, and is the driving end of the existing TAP controller. It tracks the target TAP state internally by applying the standard 16-state transition rules to every tms bit it issues.

## Interface
- MXSTATE, 4: TAP state code width.
- MXDATA, 32: maximum scan length and width of the data registers.
- MXNB, 6: width of nbits.
- clock  in  1  system clock; tck is derived from it.
- ntrst  in  1  asynchronous, active-low reset. The whole block is reset immediately on assertion.
- start  in  1  one-clock command strobe. Sampled only when busy=0.
- cmd  in  2  0=DR scan, 1=IR scan, 2=TAP reset, 3=idle clocks.
- nbits  in  MXNB  scan length or idle count. 0→1; >MXDATA→MXDATA.
- wr_data  in  MXDATA  tdi payload, shifted LSB first.
- rd_data  out  MXDATA  captured tdo. rd_data[i] = bit i. Bits ≥ nbits are 0.
- busy  out  1  high from the clock after start until done.
- done  out  1  one-clock pulse at command completion.
- tck  out  1  JTAG clock, registered.
- tms  out  1  JTAG mode select, registered.
- tdi  out  1  JTAG data out, registered.
- tdo  in  1  JTAG data in from the chain.
- tap_state  out  MXSTATE  tracked target TAP state, using the team TAP encoding (test_logic_reset=0 … update_ir=F).

## Operation
- Reset values: tck=0, tms=1, tdi=0, busy=0, done=0, rd_data=0, tap_state=test_logic_reset.
- Each tck period is 2 clocks: a low phase, then a high phase.
- tms and tdi change only on the clock edge that drives tck 1→0, or at command entry while tck=0.
- tdo is sampled on the clock edge that drives tck 1→0, i.e. at the end of the high phase.
- tap_state advances once per tck rising edge, using the issued tms value.
- Controller states: IDLE, PRE, SHIFT, POST, DONE.
  - IDLE: on start, latch cmd, nbits (after clamping) and wr_data. Clear rd_data. Go to PRE.
- Per-command tms sequences:
  - Scans (cmd 0/1) begin from run_test_idle.
  - If tap_state=test_logic_reset at start, one extra tms=0 period is prepended.
  - DR scan: PRE tms 1,0,0 (→shift_dr). SHIFT nbits periods, tms=0 except tms=1 on the last bit (→exit1_dr). POST tms 1,0 (→update_dr→run_test_idle).
  - IR scan: PRE tms 1,1,0,0 (→shift_ir). SHIFT as for DR. POST 1,0.
  - TAP reset: tms 1 ×5, then 0. Ends in run_test_idle regardless of starting state.
  - Idle clocks: nbits periods with tms=0. Valid only from run_test_idle or test_logic_reset.
- tdi during SHIFT bit i = wr_data[i]. tdi=0 outside SHIFT.
- rd_data[i] = tdo sampled at the end of SHIFT bit i.
- DONE: done=1 and busy=0 for one clock, then return to IDLE. rd_data is held until the next start.
- Boundary rules:
  - start while busy: ignored.
  - start coincident with done: ignored.
  - nbits=MXDATA: all data bits are used. The shift counter must not wrap.
  - cmd 0/1/3 issued with tap_state not in {run_test_idle, test_logic_reset}: the block first runs the TAP reset sequence, then executes the command.
  - ntrst mid-command: immediate return to reset values. No done pulse. The target is assumed reset by the same ntrst.

## Timing
- Command length in tck periods:
  - DR scan: N = nbits + 5.
  - IR scan: N = nbits + 6.
  - TAP reset: N = 6.
  - Idle clocks: N = nbits.
  - Add 1 for a prepended tms=0 period.
- start accepted at edge 0. busy=1 after edge 0. First tck rise after edge 1. done=1 after edge 2N+1.
- Back-to-back commands: next start is accepted in the clock after done. Minimum gap is 1 clock.

## Structure
- Shared include jtag_defs.vh holds the constants common with the TAP controller:
  - the 16 TAP state codes;
  - cmd codes JCMD_DR, JCMD_IR, JCMD_RST, JCMD_IDLE;
  - a function tap_next(state, tms) implementing the TAP transition table.
- No sub-module is needed. The shift counter, tck phase bit, tms sequencer and capture shift register are inline, about 250 lines.

## Test plan
- DR loopback: bench TAP controller on tck/tms/tdi with tdo looped to the TAP's registered tdo; cmd=0, nbits=8, wr_data=0xA5. Required: rd_data=0x000000A5, done 27 clocks after start, tap_state=run_test_idle.
- IR scan from reset: after ntrst, cmd=1, nbits=5, wr_data=0x1F. Required: extra tms=0 period prepended, bench TAP passes through shift_ir for exactly 5 tck rises, done after 2·12+1=25 clocks.
- Full width: cmd=0, nbits=32, wr_data=0xDEADBEEF, loopback. Required: rd_data=0xDEADBEEF. nbits=40 gives the same result.
- TAP reset: force bench TAP to shift_dr, issue cmd=2. Required: tms sequence 1,1,1,1,1,0, bench TAP ends in run_test_idle, and bench tap state equals tap_state.
- start held during busy: pulse start mid-scan. Required: no effect, exactly one done.
- ntrst asserted mid-SHIFT: all outputs return to reset values immediately, no done pulse. A following cmd=0 completes correctly.

Source files
------------

// File: rtl/jtag_master_pkg.sv
// jtag_master_pkg
//   Constants shared between the JTAG initiator and the TAP controller:
//   widths, the 16 TAP state codes, command codes, the TAP transition
//   function, and the helpers that plan a command's tms sequence.
//   No ports (package).

package jtag_master_pkg;

    localparam int MXSTATE = 4;
    localparam int MXDATA  = 32;
    localparam int MXNB    = 6;
    localparam int MXIDX   = 5;
    localparam int MXPRE   = 10;

    typedef enum logic [MXSTATE-1:0] {
        test_logic_reset = 4'h0,
        run_test_idle    = 4'h1,
        select_dr_scan   = 4'h2,
        capture_dr       = 4'h3,
        shift_dr         = 4'h4,
        exit1_dr         = 4'h5,
        pause_dr         = 4'h6,
        exit2_dr         = 4'h7,
        update_dr        = 4'h8,
        select_ir_scan   = 4'h9,
        capture_ir       = 4'ha,
        shift_ir         = 4'hb,
        exit1_ir         = 4'hc,
        pause_ir         = 4'hd,
        exit2_ir         = 4'he,
        update_ir        = 4'hf
    } tap_state_t;

    localparam logic [1:0] JCMD_DR   = 2'd0;
    localparam logic [1:0] JCMD_IR   = 2'd1;
    localparam logic [1:0] JCMD_RST  = 2'd2;
    localparam logic [1:0] JCMD_IDLE = 2'd3;

    typedef enum logic [2:0] {
        ctl_idle  = 3'd0,
        ctl_pre   = 3'd1,
        ctl_shift = 3'd2,
        ctl_post  = 3'd3,
        ctl_done  = 3'd4
    } ctl_state_t;

    // tms bits issued before SHIFT, LSB first, plus how many of them there are.
    typedef struct packed {
        logic [MXPRE-1:0] tms;
        logic [3:0]       len;
    } pre_plan_t;

    // Five ones force test_logic_reset from anywhere; the trailing zero lands in run_test_idle.
    localparam logic [MXPRE-1:0] RST_SEQ = 10'b00_0001_1111;
    localparam logic [MXNB-1:0]  NB_MAX  = MXNB'(MXDATA);

    function automatic tap_state_t tap_next(tap_state_t s, logic tms);
        tap_state_t n;
        case (s)
            test_logic_reset: n = tms ? test_logic_reset : run_test_idle;
            run_test_idle:    n = tms ? select_dr_scan   : run_test_idle;
            select_dr_scan:   n = tms ? select_ir_scan   : capture_dr;
            capture_dr:       n = tms ? exit1_dr         : shift_dr;
            shift_dr:         n = tms ? exit1_dr         : shift_dr;
            exit1_dr:         n = tms ? update_dr        : pause_dr;
            pause_dr:         n = tms ? exit2_dr         : pause_dr;
            exit2_dr:         n = tms ? update_dr        : shift_dr;
            update_dr:        n = tms ? select_dr_scan   : run_test_idle;
            select_ir_scan:   n = tms ? test_logic_reset : capture_ir;
            capture_ir:       n = tms ? exit1_ir         : shift_ir;
            shift_ir:         n = tms ? exit1_ir         : shift_ir;
            exit1_ir:         n = tms ? update_ir        : pause_ir;
            pause_ir:         n = tms ? exit2_ir         : pause_ir;
            exit2_ir:         n = tms ? update_ir        : shift_ir;
            update_ir:        n = tms ? select_dr_scan   : run_test_idle;
            default:          n = test_logic_reset;
        endcase
        return n;
    endfunction

    // 0 means one bit, anything past the register width saturates.
    function automatic logic [MXNB-1:0] clamp_nbits(logic [MXNB-1:0] n);
        logic [MXNB-1:0] r;
        if (n == '0)
            r = MXNB'(1);
        else if (n > NB_MAX)
            r = NB_MAX;
        else
            r = n;
        return r;
    endfunction

    // Everything issued before the first shift/idle bit. A TAP outside the
    // two settled states gets a full reset first; scans starting from
    // test_logic_reset need one tms=0 to reach run_test_idle.
    function automatic pre_plan_t pre_plan(logic [1:0] cmd, tap_state_t tap);
        pre_plan_t        p;
        logic [MXPRE-1:0] core;
        logic [3:0]       core_len;
        logic             settled;
        settled = (tap == test_logic_reset) || (tap == run_test_idle);
        core     = '0;
        core_len = '0;
        if (cmd == JCMD_DR) begin
            core     = 10'b00_0000_0001;
            core_len = 4'd3;
        end else if (cmd == JCMD_IR) begin
            core     = 10'b00_0000_0011;
            core_len = 4'd4;
        end
        if (cmd == JCMD_RST) begin
            p.tms = RST_SEQ;
            p.len = 4'd6;
        end else if (!settled) begin
            p.tms = (core << 6) | RST_SEQ;
            p.len = core_len + 4'd6;
        end else if (tap == test_logic_reset && cmd != JCMD_IDLE) begin
            p.tms = core << 1;
            p.len = core_len + 4'd1;
        end else begin
            p.tms = core;
            p.len = core_len;
        end
        return p;
    endfunction

endpackage

// File: rtl/jtag_master.sv
// jtag_master
//   JTAG initiator. One command per start strobe: DR scan, IR scan, TAP
//   reset or idle clocks. Each tck period is two clocks (low, then high).
//   tms/tdi change and tdo is sampled on the clock that drops tck. The
//   target TAP state is tracked by applying every issued tms bit.
// Ports
//   clock      system clock
//   ntrst      async active-low reset
//   start      command strobe, honoured only when idle
//   cmd        0 DR scan, 1 IR scan, 2 TAP reset, 3 idle clocks
//   nbits      scan length / idle count (0->1, >32->32)
//   wr_data    tdi payload, LSB first
//   rd_data    captured tdo, bit i from shift bit i, upper bits zero
//   busy       command in progress
//   done       one-clock completion pulse
//   tck/tms/tdi  registered JTAG outputs
//   tdo        JTAG data from chain
//   tap_state  tracked target TAP state
//
// state     | meaning
// ----------+-----------------------------------------------------
// ctl_idle  | waiting for start
// ctl_pre   | issuing reset/prefix/navigation tms bits from pre_q
// ctl_shift | data bits (scan) or tms=0 periods (idle clocks)
// ctl_post  | tms 1,0 back to run_test_idle after a scan
// ctl_done  | one clock, done pulse is registered from here

module jtag_master
    import jtag_master_pkg::*;
(
    input  logic               clock,
    input  logic               ntrst,
    input  logic               start,
    input  logic [1:0]         cmd,
    input  logic [MXNB-1:0]    nbits,
    input  logic [MXDATA-1:0]  wr_data,
    output logic [MXDATA-1:0]  rd_data,
    output logic               busy,
    output logic               done,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic [MXSTATE-1:0] tap_state
);

    ctl_state_t        state_q, state_d;
    tap_state_t        tap_q, tap_d;
    logic              tck_q, tck_d;
    logic              tms_q, tms_d;
    logic              tdi_q, tdi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [MXNB-1:0]   nb_q, nb_d;
    logic [MXNB-1:0]   cnt_q, cnt_d;
    logic [MXDATA-1:0] wr_q, wr_d;
    logic [MXDATA-1:0] rd_q, rd_d;
    logic [MXPRE-1:0]  pre_q, pre_d;
    logic [3:0]        precnt_q, precnt_d;
    logic              post_q, post_d;

    logic              accept;
    logic              is_scan;
    logic [MXNB-1:0]   nb_clamped;
    logic [MXIDX-1:0]  idx;
    pre_plan_t         plan;

    // A start in the done cycle is dropped, so back-to-back needs one idle clock.
    assign accept     = (state_q == ctl_idle) && start && !done_q;
    assign is_scan    = (cmd_q == JCMD_DR) || (cmd_q == JCMD_IR);
    assign nb_clamped = clamp_nbits(nbits);
    assign plan       = pre_plan(cmd, tap_q);
    // cnt_q counts bits still to go after the current one, so this is the current bit.
    assign idx        = MXIDX'(nb_q - cnt_q - MXNB'(1));

    always_ff @(posedge clock or negedge ntrst) begin
        if (!ntrst) begin
            state_q  <= ctl_idle;
            tap_q    <= test_logic_reset;
            tck_q    <= 1'b0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cmd_q    <= '0;
            nb_q     <= '0;
            cnt_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            pre_q    <= '0;
            precnt_q <= '0;
            post_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            tck_q    <= tck_d;
            tms_q    <= tms_d;
            tdi_q    <= tdi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cmd_q    <= cmd_d;
            nb_q     <= nb_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            pre_q    <= pre_d;
            precnt_q <= precnt_d;
            post_q   <= post_d;
        end
    end

    // Segment changes happen only on the tck-falling clock (tck_q high).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ctl_idle:
                if (accept)
                    state_d = (plan.len != 4'd0) ? ctl_pre : ctl_shift;
            ctl_pre:
                if (tck_q && precnt_q == 4'd0)
                    state_d = (cmd_q == JCMD_RST) ? ctl_done : ctl_shift;
            ctl_shift:
                if (tck_q && cnt_q == '0)
                    state_d = (cmd_q == JCMD_IDLE) ? ctl_done : ctl_post;
            ctl_post:
                if (tck_q && !post_q)
                    state_d = ctl_done;
            ctl_done:
                state_d = ctl_idle;
            default:
                state_d = ctl_idle;
        endcase
    end

    always_comb begin
        tap_d    = tap_q;
        tck_d    = tck_q;
        tms_d    = tms_q;
        tdi_d    = tdi_q;
        cmd_d    = cmd_q;
        nb_d     = nb_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        pre_d    = pre_q;
        precnt_d = precnt_q;
        post_d   = post_q;
        done_d   = (state_q == ctl_done);
        busy_d   = (state_d != ctl_idle);

        case (state_q)
            ctl_idle: begin
                if (accept) begin
                    cmd_d    = cmd;
                    nb_d     = nb_clamped;
                    cnt_d    = nb_clamped - MXNB'(1);
                    wr_d     = wr_data;
                    rd_d     = '0;
                    pre_d    = plan.tms;
                    precnt_d = plan.len - 4'd1;
                    post_d   = 1'b1;
                    tck_d    = 1'b0;
                    tdi_d    = 1'b0;
                    // Without a prefix only idle clocks remain, and those run with tms=0.
                    tms_d    = (plan.len != 4'd0) ? plan.tms[0] : 1'b0;
                end
            end
            ctl_pre, ctl_shift, ctl_post: begin
                if (!tck_q) begin
                    tck_d = 1'b1;
                    tap_d = tap_next(tap_q, tms_q);
                end else begin
                    tck_d = 1'b0;
                    case (state_q)
                        ctl_pre: begin
                            if (precnt_q != 4'd0) begin
                                pre_d    = pre_q >> 1;
                                precnt_d = precnt_q - 4'd1;
                                tms_d    = pre_q[1];
                            end else begin
                                tdi_d = is_scan ? wr_q[0] : 1'b0;
                                tms_d = is_scan && (cnt_q == '0);
                            end
                        end
                        ctl_shift: begin
                            if (is_scan)
                                rd_d[idx] = tdo;
                            if (cnt_q != '0) begin
                                cnt_d = cnt_q - MXNB'(1);
                                wr_d  = wr_q >> 1;
                                tdi_d = is_scan ? wr_q[1] : 1'b0;
                                tms_d = is_scan && (cnt_q == MXNB'(1));
                            end else begin
                                tdi_d = 1'b0;
                                tms_d = is_scan;
                            end
                        end
                        default: begin
                            if (post_q) begin
                                post_d = 1'b0;
                                tms_d  = 1'b0;
                            end
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign rd_data   = rd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign tap_state = tap_q;

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master
//   Drives jtag_master against a behavioural TAP on the JTAG pins whose tdo
//   is the tdi bit registered on tck rise while shifting (loopback).
//   Expected tms streams, latency and read data come from a list-based
//   command model.

module tb_jtag_master;

    logic        clock = 1'b0;
    logic        ntrst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  cmd = 2'd0;
    logic [5:0]  nbits = 6'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] rd_data;
    logic        busy, done, tck, tms, tdi, tdo;
    logic [3:0]  tap_state;

    jtag_master dut (
        .clock     (clock),
        .ntrst     (ntrst),
        .start     (start),
        .cmd       (cmd),
        .nbits     (nbits),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tap_state (tap_state)
    );

    always #5 clock = ~clock;

    // Bench TAP: 0=TLR 1=RTI 4=shift_dr 11=shift_ir (team encoding)
    int   b_st = 0;
    logic tdo_r = 1'b0;
    int   rise_cnt = 0;
    logic hist_tms [0:8191];
    int   hist_st  [0:8191];
    logic frc = 1'b0;
    int   frc_val = 0;

    function automatic int bnext(input int s, input logic t);
        case (s)
            0:  return t ? 0  : 1;
            1:  return t ? 2  : 1;
            2:  return t ? 9  : 3;
            3:  return t ? 5  : 4;
            4:  return t ? 5  : 4;
            5:  return t ? 8  : 6;
            6:  return t ? 7  : 6;
            7:  return t ? 8  : 4;
            8:  return t ? 2  : 1;
            9:  return t ? 0  : 10;
            10: return t ? 12 : 11;
            11: return t ? 12 : 11;
            12: return t ? 15 : 13;
            13: return t ? 14 : 13;
            14: return t ? 15 : 11;
            default: return t ? 2 : 1;
        endcase
    endfunction

    always @(posedge tck or negedge ntrst or posedge frc) begin
        if (!ntrst) begin
            b_st  <= 0;
            tdo_r <= 1'b0;
        end else if (frc) begin
            b_st <= frc_val;
        end else begin
            if (b_st == 4 || b_st == 11)
                tdo_r <= tdi;
            hist_tms[rise_cnt] <= tms;
            hist_st[rise_cnt]  <= b_st;
            rise_cnt           <= rise_cnt + 1;
            b_st               <= bnext(b_st, tms);
        end
    end

    assign tdo = tdo_r;

    int n_cmp = 0;
    int n_bad = 0;
    int m_state = 0;
    bit exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the full tms stream a command must produce.
    function automatic void build(input int c, input int n, input int st);
        int s;
        s = st;
        exp_q.delete();
        if (c != 2 && s != 0 && s != 1) begin
            repeat (5) exp_q.push_back(1'b1);
            exp_q.push_back(1'b0);
            s = 1;
        end
        if (c == 0 || c == 1) begin
            if (s == 0) exp_q.push_back(1'b0);
            exp_q.push_back(1'b1);
            if (c == 1) exp_q.push_back(1'b1);
            exp_q.push_back(1'b0);
            exp_q.push_back(1'b0);
            for (int i = 0; i < n; i++) exp_q.push_back(i == n - 1);
            exp_q.push_back(1'b1);
            exp_q.push_back(1'b0);
        end else if (c == 2) begin
            repeat (5) exp_q.push_back(1'b1);
            exp_q.push_back(1'b0);
        end else begin
            for (int i = 0; i < n; i++) exp_q.push_back(1'b0);
        end
    endfunction

    // pmode: 0 plain, 1 extra start pulse while busy, 2 start held in the done cycle
    task automatic run_cmd(input int c, input int nb, input logic [31:0] wd, input int pmode, input string tag);
        int n, nn, lat, base, poke_at, dones, sh;
        logic [63:0] ev, av, m, exp_rd;
        n = (nb == 0) ? 1 : ((nb > 32) ? 32 : nb);
        build(c, n, m_state);
        nn = exp_q.size();
        m = (64'd1 << n) - 64'd1;
        exp_rd = (c < 2) ? ({32'd0, wd} & m) : 64'd0;
        poke_at = (pmode == 1) ? $urandom_range(2, 2 * nn) : 0;
        @(negedge clock);
        cmd = c[1:0];
        nbits = nb[5:0];
        wr_data = wd;
        start = 1'b1;
        base = rise_cnt;
        @(posedge clock);
        #1 start = 1'b0;
        check({tag, " busy"}, {63'd0, busy}, 64'd1);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clock);
            #1;
            start = (poke_at > 1 && i == poke_at - 1);
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, lat, 2 * nn + 1);
        check({tag, " rd_data"}, {32'd0, rd_data}, exp_rd);
        check({tag, " tap_state"}, {60'd0, tap_state}, 64'd1);
        check({tag, " bench tap"}, b_st, 64'd1);
        check({tag, " tck rises"}, rise_cnt - base, nn);
        ev = '0;
        av = '0;
        for (int i = 0; i < nn && i < 64; i++) begin
            ev[i] = exp_q[i];
            av[i] = hist_tms[base + i];
        end
        check({tag, " tms stream"}, av, ev);
        if (c < 2) begin
            sh = 0;
            for (int i = 0; i < nn; i++)
                if (hist_st[base + i] == ((c == 1) ? 11 : 4)) sh++;
            check({tag, " shift rises"}, sh, n);
        end
        if (pmode == 2) start = 1'b1;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1 start = 1'b0;
            if (done) dones++;
        end
        check({tag, " extra done"}, dones, 0);
        check({tag, " idle after"}, {63'd0, busy}, 64'd0);
        m_state = 1;
    endtask

    initial begin
        int c, nb, pm, dones;
        #2 ntrst = 1'b0;
        #1;
        check("reset tck", {63'd0, tck}, 64'd0);
        check("reset tms", {63'd0, tms}, 64'd1);
        check("reset tdi", {63'd0, tdi}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset rd_data", {32'd0, rd_data}, 64'd0);
        check("reset tap_state", {60'd0, tap_state}, 64'd0);
        repeat (3) @(negedge clock);
        ntrst = 1'b1;
        m_state = 0;

        run_cmd(1, 5, 32'h1f, 0, "ir5 from reset");
        run_cmd(0, 8, 32'ha5, 0, "dr8 loopback");
        run_cmd(0, 32, 32'hdeadbeef, 0, "dr32");
        run_cmd(0, 40, 32'hdeadbeef, 0, "dr40 clamp");
        run_cmd(0, 0, 32'hffffffff, 0, "dr0 clamp");

        @(negedge clock);
        frc_val = 4;
        frc = 1'b1;
        #1 frc = 1'b0;
        run_cmd(2, 0, 32'd0, 0, "tap reset from shift_dr");
        run_cmd(0, 16, 32'h1234_5678, 1, "start while busy");
        run_cmd(3, 7, 32'd0, 2, "start with done");

        // Reset in the middle of a shift.
        @(negedge clock);
        cmd = 2'd0;
        nbits = 6'd16;
        wr_data = 32'hcafe_f00d;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (12) @(posedge clock);
        #2 ntrst = 1'b0;
        #1;
        check("mid reset tck", {63'd0, tck}, 64'd0);
        check("mid reset tms", {63'd0, tms}, 64'd1);
        check("mid reset tdi", {63'd0, tdi}, 64'd0);
        check("mid reset busy", {63'd0, busy}, 64'd0);
        check("mid reset rd_data", {32'd0, rd_data}, 64'd0);
        check("mid reset tap_state", {60'd0, tap_state}, 64'd0);
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            if (done) dones++;
        end
        check("mid reset no done", dones, 0);
        @(negedge clock);
        ntrst = 1'b1;
        m_state = 0;
        run_cmd(0, 12, 32'h0000_0abc, 0, "dr after reset");

        for (int r = 0; r < 40; r++) begin
            c  = $urandom_range(0, 3);
            nb = $urandom_range(0, 63);
            pm = $urandom_range(0, 2);
            run_cmd(c, nb, $urandom, pm, $sformatf("rand%0d c%0d n%0d", r, c, nb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
